// File: rtl/bus_seq_ctrl.sv
// Bus sequencer execution core: fetches 13-bit program words from a sync-read
// RAM, issues transfer words to the byte master and executes control opcodes.
// Valid/ready: a transfer is accepted on any rising edge where xfer_valid and
// xfer_ready are both high; xfer_valid and its payload hold until then and
// xfer_valid never drops before acceptance except on abort or reset.
module bus_seq_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int WORD_W   = 13,
    parameter int PRESCALE = 100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              abort,
    input  logic              resume,
    output logic              busy,
    output logic              paused,
    output logic              done,
    output logic [1:0]        err_code,
    output logic [7:0]        last_rdata,
    output logic              cmp_flag,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              xfer_valid,
    input  logic              xfer_ready,
    output logic [7:0]        xfer_data,
    output logic [3:0]        xfer_cnfg,
    input  logic              xfer_done,
    input  logic [7:0]        xfer_rdata,
    input  logic              xfer_err,
    output logic [2:0]        dbg_state
);

    // Delay counter holds up to 256*PRESCALE-1; jump arithmetic needs one
    // bit above the wider of PC and offset so out-of-range results show up.
    localparam int DLY_W = $clog2(256 * PRESCALE);
    localparam int JW    = ((ADDR_W > 8) ? ADDR_W : 8) + 1;

    localparam logic [2:0] OP_STOP  = 3'd0;
    localparam logic [2:0] OP_WAIT  = 3'd1;
    localparam logic [2:0] OP_CMP   = 3'd2;
    localparam logic [2:0] OP_CJMP  = 3'd3;
    localparam logic [2:0] OP_PAUSE = 3'd4;
    localparam logic [2:0] OP_JMP   = 3'd5;

    localparam logic [1:0] ERR_CMP = 2'd1;
    localparam logic [1:0] ERR_PC  = 2'd2;
    localparam logic [1:0] ERR_BUS = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_EXEC      = 3'd2,
        S_XFER_REQ  = 3'd3,
        S_XFER_WAIT = 3'd4,
        S_DELAY     = 3'd5,
        S_PAUSE     = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        err_q, err_d;
    logic [7:0]        last_rdata_q, last_rdata_d;
    logic              cmp_q, cmp_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [11:0]       word_q, word_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic              abort_pend_q, abort_pend_d;

    // Decoded fields of the word returned by the RAM in EXEC
    logic              w_cmd;
    logic [2:0]        w_op;
    logic              w_cnfg;
    logic [7:0]        w_data;
    logic [ADDR_W:0]   pc_inc;
    logic [JW-1:0]     jmp_base, jmp_off, jmp_tgt;
    logic              jmp_ovf;
    logic [DLY_W-1:0]  dly_load;
    logic              go_end, go_next, go_jump;

    assign w_cmd    = mem_rdata[0];
    assign w_op     = mem_rdata[3:1];
    assign w_cnfg   = mem_rdata[4];
    assign w_data   = mem_rdata[12:5];
    assign pc_inc   = {1'b0, pc_q} + {{ADDR_W{1'b0}}, 1'b1};
    assign jmp_base = {{(JW-ADDR_W){1'b0}}, pc_q};
    assign jmp_off  = {{(JW-8){1'b0}}, w_data};
    assign jmp_tgt  = w_cnfg ? (jmp_base - jmp_off) : (jmp_base + jmp_off);
    assign jmp_ovf  = |jmp_tgt[JW-1:ADDR_W];
    // Loaded value is cycles-1 so DELAY lasts exactly (data+1)*PRESCALE cycles
    assign dly_load = DLY_W'((32'(w_data) + 32'd1) * 32'(PRESCALE) - 32'd1);

    assign busy       = busy_q;
    assign done       = done_q;
    assign paused     = (state_q == S_PAUSE);
    assign err_code   = err_q;
    assign last_rdata = last_rdata_q;
    assign cmp_flag   = cmp_q;
    assign mem_rd_en  = (state_q == S_FETCH);
    assign mem_addr   = pc_q;
    assign xfer_valid = (state_q == S_XFER_REQ);
    assign xfer_data  = word_q[11:4];
    assign xfer_cnfg  = word_q[3:0];
    assign dbg_state  = state_q;

    // Next-state and datapath decode; end/advance/jump resolved at the bottom
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        err_d        = err_q;
        last_rdata_d = last_rdata_q;
        cmp_d        = cmp_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        word_d       = word_q;
        dly_d        = dly_q;
        abort_pend_d = abort_pend_q;
        go_end       = 1'b0;
        go_next      = 1'b0;
        go_jump      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d    = start_addr;
                    err_d   = 2'd0;
                    cmp_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (abort) go_end = 1'b1;
                else       state_d = S_EXEC;
            end
            S_EXEC: begin
                if (abort) begin
                    go_end = 1'b1;
                end else if (w_cmd) begin
                    word_d  = mem_rdata[12:1];
                    state_d = S_XFER_REQ;
                end else begin
                    case (w_op)
                        OP_STOP: go_end = 1'b1;
                        OP_WAIT: begin
                            dly_d   = dly_load;
                            state_d = S_DELAY;
                        end
                        OP_CMP: begin
                            cmp_d = (last_rdata_q == w_data);
                            if (w_cnfg && (last_rdata_q != w_data)) begin
                                err_d  = ERR_CMP;
                                go_end = 1'b1;
                            end else begin
                                go_next = 1'b1;
                            end
                        end
                        OP_CJMP: begin
                            if (cmp_q) go_jump = 1'b1;
                            else       go_next = 1'b1;
                        end
                        OP_PAUSE: state_d = S_PAUSE;
                        OP_JMP:   go_jump = 1'b1;
                        default:  go_next = 1'b1;
                    endcase
                end
            end
            S_XFER_REQ: begin
                // Once accepted the bus transfer must complete, so a
                // coincident abort is remembered rather than acted on.
                if (xfer_ready) begin
                    abort_pend_d = abort;
                    state_d      = S_XFER_WAIT;
                end else if (abort) begin
                    go_end = 1'b1;
                end
            end
            S_XFER_WAIT: begin
                if (abort) abort_pend_d = 1'b1;
                if (xfer_done) begin
                    last_rdata_d = xfer_rdata;
                    if (xfer_err) begin
                        err_d  = ERR_BUS;
                        go_end = 1'b1;
                    end else if (abort_pend_q || abort) begin
                        go_end = 1'b1;
                    end else begin
                        go_next = 1'b1;
                    end
                end
            end
            S_DELAY: begin
                if (abort)              go_end = 1'b1;
                else if (dly_q == '0)   go_next = 1'b1;
                else                    dly_d = dly_q - 1'b1;
            end
            S_PAUSE: begin
                if (abort)       go_end = 1'b1;
                else if (resume) go_next = 1'b1;
            end
            default: go_end = 1'b1;
        endcase

        if (go_jump) begin
            if (jmp_ovf) begin
                err_d = ERR_PC;
            end else begin
                pc_d    = jmp_tgt[ADDR_W-1:0];
                state_d = S_FETCH;
            end
        end
        if (go_next) begin
            if (pc_inc[ADDR_W]) begin
                err_d = ERR_PC;
            end else begin
                pc_d    = pc_inc[ADDR_W-1:0];
                state_d = S_FETCH;
            end
        end
        if (go_end || (go_jump && jmp_ovf) || (go_next && pc_inc[ADDR_W])) begin
            state_d      = S_IDLE;
            busy_d       = 1'b0;
            done_d       = 1'b1;
            abort_pend_d = 1'b0;
        end
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            err_q        <= 2'd0;
            last_rdata_q <= 8'd0;
            cmp_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            word_q       <= 12'd0;
            dly_q        <= '0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            err_q        <= err_d;
            last_rdata_q <= last_rdata_d;
            cmp_q        <= cmp_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            word_q       <= word_d;
            dly_q        <= dly_d;
            abort_pend_q <= abort_pend_d;
        end
    end

endmodule
